// File: rtl/bus_rr_xfer_pkg.sv
// Shared definitions for the round-robin bus interconnect.
// Holds the FSM state encoding and the round-robin pointer helper.
package bus_rr_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        DELIVER = 2'd2
    } bus_state_e;

    // Next position after idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/bus_req_fifo.sv
// Per-source request FIFO: registered occupancy count, flags derived from the count only.
// DEPTH must be a power of two so the pointers wrap naturally.
module bus_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bus_rr_xfer.sv
// Shared-bus interconnect: per-source FIFOs, round-robin grant, fixed bus occupancy,
// then unicast/broadcast delivery with per-destination backpressure.
module bus_rr_xfer
    import bus_rr_xfer_pkg::*;
#(
    parameter int NUM_PROC      = 4,
    parameter int ADDR_W        = 48,
    parameter int DATA_W        = 64,
    parameter int FIFO_DEPTH    = 4,
    parameter int TRANSFER_TIME = 10,
    parameter int DEST_W        = $clog2(NUM_PROC + 1)
) (
    input  logic                               clk,
    input  logic                               rst_l,
    input  logic [NUM_PROC-1:0]                in_valid,
    output logic [NUM_PROC-1:0]                in_ready,
    input  logic [NUM_PROC-1:0][DEST_W-1:0]    in_dest,
    input  logic [NUM_PROC-1:0][ADDR_W-1:0]    in_addr,
    input  logic [NUM_PROC-1:0][DATA_W-1:0]    in_data,
    output logic [NUM_PROC-1:0]                out_valid,
    input  logic [NUM_PROC-1:0]                out_ready,
    output logic [$clog2(NUM_PROC)-1:0]        out_src,
    output logic [ADDR_W-1:0]                  out_addr,
    output logic [DATA_W-1:0]                  out_data,
    output logic                               bus_busy,
    output logic                               drop_err
);

    localparam int SRC_W = $clog2(NUM_PROC);
    localparam int CNT_W = $clog2(TRANSFER_TIME + 1);

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [DEST_W-1:0] dest;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    logic [NUM_PROC-1:0] full;
    logic [NUM_PROC-1:0] empty;
    logic [NUM_PROC-1:0] pop;
    logic [REQ_W-1:0]    head [NUM_PROC];

    for (genvar i = 0; i < NUM_PROC; i++) begin : g_src
        req_t push_req;

        assign push_req = '{src:  SRC_W'(i),
                            dest: in_dest[i],
                            addr: in_addr[i],
                            data: in_data[i]};

        bus_req_fifo #(
            .WIDTH (REQ_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_l     (rst_l),
            .push      (in_valid[i]),
            .push_data (push_req),
            .pop       (pop[i]),
            .full      (full[i]),
            .empty     (empty[i]),
            .head      (head[i])
        );
    end

    assign in_ready = ~full;

    bus_state_e          state, state_d;
    logic [SRC_W-1:0]    rr_ptr, rr_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [NUM_PROC-1:0] pend, pend_d;
    req_t                xfer, xfer_d;
    logic                drop_q, drop_d;

    logic                win_found;
    logic [SRC_W-1:0]    win;
    logic [SRC_W-1:0]    cand;
    logic [NUM_PROC-1:0] deliver_mask;
    logic [NUM_PROC-1:0] accept;

    // First non-empty FIFO starting at rr_ptr, wrapping modulo NUM_PROC.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_PROC; k++) begin
            cand = SRC_W'((32'(rr_ptr) + k) % NUM_PROC);
            if (!win_found && !empty[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
    end

    // Broadcast reaches everyone but the sender; an out-of-range dest yields no target.
    always_comb begin
        deliver_mask = '0;
        if (xfer.dest == DEST_W'(NUM_PROC)) begin
            deliver_mask            = '1;
            deliver_mask[xfer.src]  = 1'b0;
        end else if (xfer.dest < DEST_W'(NUM_PROC)) begin
            deliver_mask[SRC_W'(xfer.dest)] = 1'b1;
        end
    end

    assign out_valid = (state == DELIVER) ? pend : '0;
    assign accept    = out_valid & out_ready;

    always_comb begin
        state_d = state;
        rr_d    = rr_ptr;
        cnt_d   = cnt;
        pend_d  = pend;
        xfer_d  = xfer;
        drop_d  = 1'b0;
        pop     = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    pop[win] = 1'b1;
                    xfer_d   = req_t'(head[win]);
                    rr_d     = SRC_W'(rr_next(32'(win), NUM_PROC));
                    cnt_d    = CNT_W'(TRANSFER_TIME - 1);
                    state_d  = XFER;
                end
            end
            XFER: begin
                if (cnt == '0) begin
                    pend_d = deliver_mask;
                    if (deliver_mask != '0) begin
                        state_d = DELIVER;
                    end else begin
                        state_d = IDLE;
                        drop_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            DELIVER: begin
                pend_d = pend & ~accept;
                if (pend_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cnt    <= '0;
            pend   <= '0;
            xfer   <= '0;
            drop_q <= 1'b0;
        end else begin
            state  <= state_d;
            rr_ptr <= rr_d;
            cnt    <= cnt_d;
            pend   <= pend_d;
            xfer   <= xfer_d;
            drop_q <= drop_d;
        end
    end

    assign out_src  = (state == DELIVER) ? xfer.src  : '0;
    assign out_addr = (state == DELIVER) ? xfer.addr : '0;
    assign out_data = (state == DELIVER) ? xfer.data : '0;
    assign bus_busy = (state != IDLE);
    assign drop_err = drop_q;

endmodule

// File: tb/tb_bus_rr_xfer.sv
// Directed bench for bus_rr_xfer: fixed vectors with hand-derived expectations,
// checked by immediate assertions on the falling clock edge.
module tb_bus_rr_xfer;

    localparam int NP = 4;
    localparam int AW = 48;
    localparam int DW = 64;

    logic                   clk = 1'b0;
    logic                   rst_l;
    logic [NP-1:0]          in_valid;
    logic [NP-1:0]          in_ready;
    logic [NP-1:0][2:0]     in_dest;
    logic [NP-1:0][AW-1:0]  in_addr;
    logic [NP-1:0][DW-1:0]  in_data;
    logic [NP-1:0]          out_valid;
    logic [NP-1:0]          out_ready;
    logic [1:0]             out_src;
    logic [AW-1:0]          out_addr;
    logic [DW-1:0]          out_data;
    logic                   bus_busy;
    logic                   drop_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_rr_xfer #(
        .NUM_PROC      (4),
        .ADDR_W        (48),
        .DATA_W        (64),
        .FIFO_DEPTH    (4),
        .TRANSFER_TIME (10)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dest   (in_dest),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .bus_busy  (bus_busy),
        .drop_err  (drop_err)
    );

    function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
        return {16'hDA7A, a};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int s, input logic [2:0] d, input logic [AW-1:0] a);
        in_valid[s] = 1'b1;
        in_dest[s]  = d;
        in_addr[s]  = a;
        in_data[s]  = dat(a);
    endtask

    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (out_valid != '0) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic deliver_expect(input string tag, input logic [1:0] s,
                                  input logic [AW-1:0] a, input logic [NP-1:0] v);
        bit f;
        wait_valid(f);
        check({tag, " found"}, f, 1);
        check({tag, " valid"}, out_valid, v);
        check({tag, " src"}, out_src, s);
        check({tag, " addr"}, out_addr, a);
        check({tag, " data"}, out_data, dat(a));
        step();
    endtask

    initial begin
        bit f;
        int hs [NP];
        bit src0_seen;
        int drops;
        int drop_at;
        bit busy_at_drop;
        bit any;

        rst_l     = 1'b0;
        in_valid  = '0;
        in_dest   = '0;
        in_addr   = '0;
        in_data   = '0;
        out_ready = '0;
        repeat (3) step();

        // reset state
        check("rst out_valid", out_valid, 0);
        check("rst out_src", out_src, 0);
        check("rst out_addr", out_addr, 0);
        check("rst out_data", out_data, 0);
        check("rst bus_busy", bus_busy, 0);
        check("rst drop_err", drop_err, 0);
        check("rst in_ready", in_ready, 4'hF);
        rst_l = 1'b1;
        step();

        // round robin: all four push together, then 0,2 and 0 again
        out_ready = '1;
        for (int s = 0; s < NP; s++) set_req(s, 3'd3, 48'h100 * (s + 1));
        step();
        in_valid = '0;
        for (int s = 0; s < NP; s++)
            deliver_expect($sformatf("rr1 #%0d", s), 2'(s), 48'h100 * (s + 1), 4'b1000);
        set_req(0, 3'd3, 48'h2000);
        set_req(2, 3'd3, 48'h2200);
        step();
        in_valid = '0;
        set_req(0, 3'd3, 48'h2001);
        step();
        in_valid = '0;
        deliver_expect("rr2 a", 2'd0, 48'h2000, 4'b1000);
        deliver_expect("rr2 b", 2'd2, 48'h2200, 4'b1000);
        deliver_expect("rr2 c", 2'd0, 48'h2001, 4'b1000);

        // single unicast with exact latency: push P, grant P+1, valid after P+11
        out_ready = 4'b1000;
        set_req(1, 3'd3, 48'h1000);
        step();
        in_valid = '0;
        check("t1 busy before grant", bus_busy, 0);
        check("t1 in_ready", in_ready, 4'hF);
        step();
        check("t1 busy at grant", bus_busy, 1);
        check("t1 valid at grant", out_valid, 0);
        for (int k = 0; k < 9; k++) begin
            step();
            check($sformatf("t1 no early valid %0d", k), out_valid, 0);
        end
        step();
        check("t1 valid", out_valid, 4'b1000);
        check("t1 src", out_src, 1);
        check("t1 addr", out_addr, 48'h1000);
        check("t1 data", out_data, dat(48'h1000));
        step();
        check("t1 valid after hs", out_valid, 0);
        check("t1 busy after hs", bus_busy, 0);

        // backpressure and FIFO full
        out_ready = '0;
        set_req(1, 3'd3, 48'h3100);
        step();
        in_valid = '0;
        step();
        check("bp busy", bus_busy, 1);
        for (int k = 0; k < 5; k++) begin
            set_req(2, 3'd0, 48'h3200 + k);
            check($sformatf("bp in_ready %0d", k), in_ready[2], (k < 4) ? 1 : 0);
            step();
        end
        in_valid = '0;
        check("bp in_ready full", in_ready, 4'b1011);
        wait_valid(f);
        check("bp found", f, 1);
        check("bp valid held", out_valid, 4'b1000);
        check("bp addr", out_addr, 48'h3100);
        repeat (3) step();
        check("bp valid still", out_valid, 4'b1000);
        check("bp addr stable", out_addr, 48'h3100);
        check("bp data stable", out_data, dat(48'h3100));
        out_ready = '1;
        deliver_expect("bp src1", 2'd1, 48'h3100, 4'b1000);
        for (int k = 0; k < 4; k++)
            deliver_expect($sformatf("bp src2 #%0d", k), 2'd2, 48'h3200 + k, 4'b0001);
        step();
        check("bp fifth dropped", bus_busy, 0);
        check("bp in_ready drained", in_ready, 4'hF);

        // broadcast from src 0 with staggered destination readiness
        out_ready = 4'b0010;
        set_req(0, 3'd4, 48'h4000);
        step();
        in_valid = '0;
        wait_valid(f);
        check("bc found", f, 1);
        for (int j = 0; j < NP; j++) hs[j] = 0;
        src0_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) set_req(1, 3'd3, 48'h4100);
            if (i == 2) in_valid = '0;
            if (i == 3) out_ready[2] = 1'b1;
            if (i == 5) out_ready[3] = 1'b1;
            for (int j = 0; j < NP; j++) hs[j] += int'(out_valid[j] && out_ready[j]);
            if (out_valid[0]) src0_seen = 1'b1;
            if (i == 0) begin
                check("bc first mask", out_valid, 4'b1110);
                check("bc src", out_src, 0);
                check("bc addr", out_addr, 48'h4000);
            end
            if (i == 4) check("bc mask after 2", out_valid, 4'b1000);
            if (i == 6) begin
                check("bc done valid", out_valid, 0);
                check("bc done idle", bus_busy, 0);
            end
            if (i == 7) check("bc next grant", bus_busy, 1);
            step();
        end
        check("bc hs dest1", hs[1], 1);
        check("bc hs dest2", hs[2], 1);
        check("bc hs dest3", hs[3], 1);
        check("bc src0 never valid", src0_seen, 0);
        out_ready = '1;
        deliver_expect("bc follow", 2'd1, 48'h4100, 4'b1000);

        // illegal destination 6
        set_req(3, 3'd6, 48'h5000);
        step();
        in_valid = '0;
        drops = 0;
        drop_at = -1;
        busy_at_drop = 1'b1;
        any = 1'b0;
        for (int k = 2; k <= 20; k++) begin
            step();
            if (drop_err) begin
                drops++;
                if (drop_at < 0) begin
                    drop_at = k;
                    busy_at_drop = bus_busy;
                end
            end
            if (out_valid != '0) any = 1'b1;
        end
        check("ill drop count", drops, 1);
        check("ill drop timing", drop_at, 12);
        check("ill idle at drop", busy_at_drop, 0);
        check("ill no valid", any, 0);

        // reset during DELIVER
        out_ready = '0;
        set_req(0, 3'd2, 48'h6000);
        set_req(1, 3'd3, 48'h6100);
        step();
        in_valid = '0;
        set_req(1, 3'd3, 48'h6101);
        step();
        in_valid = '0;
        wait_valid(f);
        check("rd found", f, 1);
        check("rd valid before", out_valid, 4'b0100);
        rst_l = 1'b0;
        #1;
        check("rd valid async", out_valid, 0);
        check("rd busy async", bus_busy, 0);
        check("rd in_ready async", in_ready, 4'hF);
        check("rd addr async", out_addr, 0);
        step();
        rst_l = 1'b1;
        step();
        out_ready = '1;
        any = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (out_valid != '0 || bus_busy) any = 1'b1;
        end
        check("rd queues flushed", any, 0);
        set_req(2, 3'd1, 48'h7000);
        step();
        in_valid = '0;
        deliver_expect("rd after", 2'd2, 48'h7000, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
